sc_multi_channel_scorer: RTL and testbench

// - Parametrised successor to the score-control datapath. Accepts per-channel match pulses from the note matcher.
// - Arbitrates them round-robin into one shared event queue, grades timing error into tiers, tracks combo, accumulates a saturating score.
// - Sits between the note matcher and the AV/score display; replaces the fixed-width serializer/score pair.

---
 rtl/sc_pkg.sv | 45 ++++
 rtl/sc_rr_arbiter.sv | 45 ++++
 rtl/sc_multi_channel_scorer.sv | 181 ++++++++++++++++++
 tb/tb_sc_multi_channel_scorer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the multi-channel scorer: tier encoding, point values,
// combo multiplier and wrap-aware absolute timing error.
package sc_pkg;

  typedef enum logic [1:0] {
    TIER_PERFECT   = 2'd0,
    TIER_GOOD      = 2'd1,
    TIER_OK        = 2'd2,
    TIER_LATE_MISS = 2'd3
  } tier_e;

  localparam logic [6:0] PTS_PERFECT   = 7'd100;
  localparam logic [6:0] PTS_GOOD      = 7'd50;
  localparam logic [6:0] PTS_OK        = 7'd20;
  localparam logic [6:0] PTS_LATE_MISS = 7'd0;

  function automatic logic [6:0] tier_points(input tier_e tier);
    case (tier)
      TIER_PERFECT: return PTS_PERFECT;
      TIER_GOOD:    return PTS_GOOD;
      TIER_OK:      return PTS_OK;
      default:      return PTS_LATE_MISS;
    endcase
  endfunction

  // Multiplier from the combo count held before the current event is applied.
  function automatic logic [2:0] combo_mult(input logic [15:0] combo);
    logic [15:0] m;
    m = (combo / 16'd10) + 16'd1;
    return (m > 16'd4) ? 3'd4 : m[2:0];
  endfunction

  // Difference taken modulo 2^tw; a set MSB means an early hit, so negate it.
  function automatic logic [31:0] abs_dt(input logic [31:0] now_t,
                                         input logic [31:0] note_t,
                                         input int unsigned tw);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (tw >= 32) ? '1 : ((32'd1 << tw) - 32'd1);
    diff = (now_t - note_t) & mask;
    if (diff[tw-1]) diff = (~diff + 32'd1) & mask;
    return diff;
  endfunction

endpackage

// File: rtl/sc_rr_arbiter.sv
// Round-robin arbiter: grants the lowest pending index at or after rr_ptr and
// advances the pointer past the winner.
module sc_rr_arbiter
  import sc_pkg::*;
#(
  parameter int unsigned NCH = 37
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [NCH-1:0]         pending_i,
  output logic                   gnt_valid_o,
  output logic [$clog2(NCH)-1:0] gnt_idx_o
);

  localparam int unsigned CW = $clog2(NCH);

  logic [CW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    logic [CW-1:0] idx;
    idx         = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = CW'((32'(rr_ptr_q) + k) % NCH);
      if (en_i && !gnt_valid_o && pending_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid_o)
      rr_ptr_d = (gnt_idx_o == CW'(NCH - 1)) ? '0 : gnt_idx_o + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/sc_multi_channel_scorer.sv
// Multi-channel scorer: per-channel capture, round-robin into a shared event FIFO,
// tier grading, combo and saturating score. Define SC_COMBO_MULT_EN for combo multiplier.
module sc_multi_channel_scorer
  import sc_pkg::*;
#(
  parameter int unsigned NCH       = 37,
  parameter int unsigned TW        = 16,
  parameter int unsigned SW        = 32,
  parameter int unsigned QDEPTH    = 8,
  parameter int unsigned T_PERFECT = 8,
  parameter int unsigned T_GOOD    = 24,
  parameter int unsigned T_OK      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pause,
  input  logic [TW-1:0]          song_time,
  input  logic [NCH-1:0]         match_trigger,
  input  logic [NCH*TW-1:0]      match_time,
  input  logic                   miss,
  output logic [SW-1:0]          score,
  output logic [15:0]            combo,
  output logic                   ev_valid,
  output logic [$clog2(NCH)-1:0] ev_chan,
  output logic [TW-1:0]          ev_dt,
  output logic [1:0]             ev_tier,
  output logic [7:0]             ovf_cnt
);

  localparam int unsigned CW  = $clog2(NCH);
  localparam int unsigned QAW = $clog2(QDEPTH);
  localparam int unsigned AW  = ((SW > 10) ? SW : 10) + 1;
  localparam logic [QAW:0] PTR_ONE = (QAW + 1)'(1);

  logic [NCH-1:0] pending_q, pending_d;
  logic [TW-1:0]  time_q [NCH];
  logic [TW-1:0]  time_d [NCH];
  logic [7:0]     ovf_q, ovf_d;

  logic           gnt_valid;
  logic [CW-1:0]  gnt_idx;
  logic [31:0]    dt_full;
  logic [TW-1:0]  gnt_dt;
  logic           dt_unused;

  logic [CW-1:0]  fifo_chan_q [QDEPTH];
  logic [TW-1:0]  fifo_dt_q   [QDEPTH];
  logic [QAW:0]   wr_ptr_q, rd_ptr_q;
  logic           fifo_full, fifo_empty, push, pop;

  logic [CW-1:0]  pop_chan;
  logic [TW-1:0]  pop_dt;
  tier_e          pop_tier;
  logic [2:0]     mult;
  logic [9:0]     gain;
  logic [AW-1:0]  sum, smax;

  logic [SW-1:0]  score_q, score_d;
  logic [15:0]    combo_q, combo_d;
  logic           ev_valid_q;
  logic [CW-1:0]  ev_chan_q;
  logic [TW-1:0]  ev_dt_q;
  tier_e          ev_tier_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[QAW] != rd_ptr_q[QAW]) &&
                      (wr_ptr_q[QAW-1:0] == rd_ptr_q[QAW-1:0]);

  sc_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk         (clk),
    .rst_n       (reset),
    .en_i        (!pause && !fifo_full),
    .pending_i   (pending_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign push      = gnt_valid;
  assign dt_full   = abs_dt(32'(song_time), 32'(time_q[gnt_idx]), TW);
  assign gnt_dt    = dt_full[TW-1:0];
  assign dt_unused = |(dt_full >> TW);

  // Granted entry is released before capture so a same-cycle trigger re-arms the channel.
  always_comb begin
    logic [31:0] drops;
    logic [31:0] ovf_sum;
    drops     = '0;
    pending_d = pending_q;
    time_d    = time_q;
    if (gnt_valid) pending_d[gnt_idx] = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (match_trigger[i]) begin
        if (pending_d[i]) begin
          drops = drops + 32'd1;
        end else begin
          pending_d[i] = 1'b1;
          time_d[i]    = match_time[i*TW +: TW];
        end
      end
    end
    ovf_sum = 32'(ovf_q) + drops;
    ovf_d   = (ovf_sum > 32'd255) ? 8'hFF : ovf_sum[7:0];
  end

  assign pop      = !pause && !fifo_empty;
  assign pop_chan = fifo_chan_q[rd_ptr_q[QAW-1:0]];
  assign pop_dt   = fifo_dt_q[rd_ptr_q[QAW-1:0]];

  always_comb begin
    if (32'(pop_dt) <= T_PERFECT)   pop_tier = TIER_PERFECT;
    else if (32'(pop_dt) <= T_GOOD) pop_tier = TIER_GOOD;
    else if (32'(pop_dt) <= T_OK)   pop_tier = TIER_OK;
    else                            pop_tier = TIER_LATE_MISS;
  end

`ifdef SC_COMBO_MULT_EN
  assign mult = combo_mult(combo_q);
`else
  assign mult = 3'd1;
`endif

  assign gain = 10'(tier_points(pop_tier)) * 10'(mult);
  assign sum  = AW'(score_q) + AW'(gain);
  assign smax = (AW'(1) << SW) - AW'(1);

  always_comb begin
    score_d = (sum > smax) ? '1 : sum[SW-1:0];
    combo_d = combo_q;
    if (pop)
      combo_d = (pop_tier == TIER_LATE_MISS) ? '0 :
                (combo_q == 16'hFFFF)        ? combo_q : combo_q + 16'd1;
    if (miss) combo_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      ovf_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      score_q    <= '0;
      combo_q    <= '0;
      ev_valid_q <= 1'b0;
      ev_chan_q  <= '0;
      ev_dt_q    <= '0;
      ev_tier_q  <= TIER_PERFECT;
      for (int unsigned i = 0; i < NCH; i++) time_q[i] <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        fifo_chan_q[i] <= '0;
        fifo_dt_q[i]   <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      time_q     <= time_d;
      ovf_q      <= ovf_d;
      combo_q    <= combo_d;
      ev_valid_q <= pop;
      if (push) begin
        fifo_chan_q[wr_ptr_q[QAW-1:0]] <= gnt_idx;
        fifo_dt_q[wr_ptr_q[QAW-1:0]]   <= gnt_dt;
        wr_ptr_q                       <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        ev_chan_q <= pop_chan;
        ev_dt_q   <= pop_dt;
        ev_tier_q <= pop_tier;
        score_q   <= score_d;
      end
    end
  end

  assign score    = score_q;
  assign combo    = combo_q;
  assign ev_valid = ev_valid_q;
  assign ev_chan  = ev_chan_q;
  assign ev_dt    = ev_dt_q;
  assign ev_tier  = ev_tier_q;
  assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_sc_multi_channel_scorer.sv
// Directed bench for sc_multi_channel_scorer with an event-level scoring model;
// a second instance with SW=8 exercises score saturation on the same stimulus.
module tb_sc_multi_channel_scorer;

  localparam int NCH = 37;
  localparam int TW  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pause = 1'b0;
  logic              miss = 1'b0;
  logic [TW-1:0]     song_time = '0;
  logic [NCH-1:0]    match_trigger = '0;
  logic [NCH*TW-1:0] match_time = '0;

  logic [31:0] score;
  logic [15:0] combo;
  logic        ev_valid;
  logic [5:0]  ev_chan;
  logic [15:0] ev_dt;
  logic [1:0]  ev_tier;
  logic [7:0]  ovf_cnt;

  logic [7:0]  score8;
  logic [15:0] combo8;
  logic        ev_valid8;
  logic [5:0]  ev_chan8;
  logic [15:0] ev_dt8;
  logic [1:0]  ev_tier8;
  logic [7:0]  ovf_cnt8;

  sc_multi_channel_scorer #(.NCH(NCH), .TW(TW), .SW(32)) u_dut (
    .clk(clk), .reset(reset), .pause(pause), .song_time(song_time),
    .match_trigger(match_trigger), .match_time(match_time), .miss(miss),
    .score(score), .combo(combo), .ev_valid(ev_valid), .ev_chan(ev_chan),
    .ev_dt(ev_dt), .ev_tier(ev_tier), .ovf_cnt(ovf_cnt)
  );

  sc_multi_channel_scorer #(.NCH(NCH), .TW(TW), .SW(8)) u_dut8 (
    .clk(clk), .reset(reset), .pause(pause), .song_time(song_time),
    .match_trigger(match_trigger), .match_time(match_time), .miss(miss),
    .score(score8), .combo(combo8), .ev_valid(ev_valid8), .ev_chan(ev_chan8),
    .ev_dt(ev_dt8), .ev_tier(ev_tier8), .ovf_cnt(ovf_cnt8)
  );

  always #5 clk = ~clk;

  typedef struct { int chan; int dt; } ev_t;

  ev_t     exp_q[$];
  int      n_checks = 0;
  int      n_fail = 0;
  longint  m_score = 0;
  longint  m_score8 = 0;
  int      m_combo = 0;
  int      n_events = 0;
  bit      prev_miss = 1'b0;
  bit      prev_pause = 1'b0;
  int      last_dt = 0;
  int      last_tier = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_dt(input int t);
    logic [15:0] d;
    d = song_time - 16'(t);
    if (d[15]) d = -d;
    return int'(d);
  endfunction

  function automatic int tier_of(input int dt);
    if (dt <= 8)  return 0;
    if (dt <= 24) return 1;
    if (dt <= 64) return 2;
    return 3;
  endfunction

  function automatic int points_of(input int tier);
    case (tier)
      0: return 100;
      1: return 50;
      2: return 20;
      default: return 0;
    endcase
  endfunction

  function automatic int mult_of(input int c);
`ifdef SC_COMBO_MULT_EN
    return (c / 10 + 1 > 4) ? 4 : c / 10 + 1;
`else
    return 1;
`endif
  endfunction

  // Event-level model: every graded event must be the next expected one, and the
  // running score/combo must follow from the events and miss pulses seen so far.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_score = 0; m_score8 = 0; m_combo = 0;
      check("rst_score", score, 0);
      check("rst_combo", combo, 0);
      check("rst_ev_valid", ev_valid, 0);
      check("rst_ovf", ovf_cnt, 0);
      prev_miss = 1'b0;
      prev_pause = 1'b0;
    end else begin
      if (ev_valid) begin
        ev_t e;
        int tier;
        int gain;
        check("ev_while_paused", prev_pause, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_ev", 1, 0);
        end else begin
          e = exp_q.pop_front();
          tier = tier_of(e.dt);
          check("ev_chan", ev_chan, e.chan);
          check("ev_dt", ev_dt, e.dt);
          check("ev_tier", ev_tier, tier);
          check("ev8_valid", ev_valid8, 1);
          check("ev8_chan", ev_chan8, e.chan);
          check("ev8_tier", ev_tier8, tier);
          gain = points_of(tier) * mult_of(m_combo);
          m_score  = (m_score + gain > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_score + gain;
          m_score8 = (m_score8 + gain > 255) ? 255 : m_score8 + gain;
          m_combo  = (tier == 3) ? 0 : ((m_combo == 65535) ? m_combo : m_combo + 1);
          last_dt = ev_dt;
          last_tier = ev_tier;
        end
        n_events++;
      end else begin
        check("ev8_idle", ev_valid8, 0);
      end
      if (prev_miss) m_combo = 0;
      check("score", score, m_score);
      check("combo", combo, m_combo);
      check("score8", score8, m_score8);
      check("combo8", combo8, m_combo);
      prev_miss = miss;
      prev_pause = pause;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_trig(input int ch, input int t, input bit expect_it);
    match_trigger[ch] = 1'b1;
    match_time[ch*TW +: TW] = 16'(t);
    if (expect_it) begin
      ev_t e;
      e.chan = ch;
      e.dt = exp_dt(t);
      exp_q.push_back(e);
    end
  endtask

  task automatic fire();
    tick();
    match_trigger = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    longint s0;
    int e0;

    #1 reset = 1'b0;
    #2;
    check("init_score", score, 0);
    check("init_combo", combo, 0);
    check("init_ev_valid", ev_valid, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single perfect hit and its pipeline latency.
    song_time = 16'd1003;
    set_trig(0, 1000, 1'b1);
    fire();
    tick();
    check("lat_early_ev", ev_valid, 0);
    tick();
    check("lat_ev_valid", ev_valid, 1);
    check("lat_ev_chan", ev_chan, 0);
    check("lat_ev_dt", ev_dt, 3);
    check("lat_ev_tier", ev_tier, 0);
    check("lat_score", score, 100);
    check("lat_combo", combo, 1);
    wait_idle("drain_t1", 10);

    // Early hit graded OK, then a late miss clears the combo.
    song_time = 16'd470;
    set_trig(1, 500, 1'b1);
    fire();
    wait_idle("drain_early", 10);
    check("early_dt", last_dt, 30);
    check("early_tier", last_tier, 2);
    check("early_score", score, 120);
    check("early_combo", combo, 2);
    song_time = 16'd600;
    set_trig(2, 500, 1'b1);
    fire();
    wait_idle("drain_late", 10);
    check("late_tier", last_tier, 3);
    check("late_score", score, 120);
    check("late_combo", combo, 0);

    // All channels at once after reset: channel order, overflow on ch5 re-trigger.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    song_time = 16'd2000;
    e0 = n_events;
    for (int ch = 0; ch < NCH; ch++) set_trig(ch, 2000 - 2 * ch, 1'b1);
    fire();
    set_trig(5, 1234, 1'b0);
    fire();
    wait_idle("drain_all", 120);
    check("all_event_count", n_events - e0, 37);
    check("all_ovf", ovf_cnt, 1);
    check("all_ovf8", ovf_cnt8, 1);

    // Combo run of 35 perfect hits after a miss.
    miss = 1'b1;
    tick();
    miss = 1'b0;
    tick();
    check("miss_combo", combo, 0);
    s0 = score;
    song_time = 16'd3000;
    for (int ch = 0; ch < 35; ch++) set_trig(ch, 3000, 1'b1);
    fire();
    wait_idle("drain_combo", 120);
`ifdef SC_COMBO_MULT_EN
    check("combo_run_gain", score - s0, 8000);
`else
    check("combo_run_gain", score - s0, 3500);
`endif
    check("combo_run_combo", combo, 35);
    check("sat_score8", score8, 255);

    // Pause with three pendings, then release.
    pause = 1'b1;
    song_time = 16'd4000;
    s0 = score;
    e0 = n_events;
    set_trig(3, 4000, 1'b1);
    set_trig(7, 4000, 1'b1);
    set_trig(9, 4000, 1'b1);
    fire();
    repeat (20) tick();
    check("pause_no_events", n_events - e0, 0);
    check("pause_score_held", score, s0);
    pause = 1'b0;
    wait_idle("drain_pause", 20);
    check("pause_release_events", n_events - e0, 3);

    // Miss in the same cycle as a graded hit.
    song_time = 16'd5000;
    s0 = score;
    set_trig(0, 5000, 1'b1);
    fire();
    tick();
    miss = 1'b1;
    tick();
    miss = 1'b0;
    check("miss_hit_ev", ev_valid, 1);
    check("miss_hit_combo", combo, 0);
`ifdef SC_COMBO_MULT_EN
    check("miss_hit_gain", score - s0, 400);
`else
    check("miss_hit_gain", score - s0, 100);
`endif
    wait_idle("drain_miss", 10);

    // Asynchronous reset in the middle of a burst.
    song_time = 16'd6000;
    for (int ch = 0; ch < 10; ch++) set_trig(ch, 6000, 1'b1);
    fire();
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("midrst_score", score, 0);
    check("midrst_combo", combo, 0);
    check("midrst_ev_valid", ev_valid, 0);
    check("midrst_ovf", ovf_cnt, 0);
    check("midrst_score8", score8, 0);
    tick(); tick();
    reset = 1'b1;
    e0 = n_events;
    repeat (10) tick();
    check("post_rst_quiet", n_events - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
